ether_tx_frame_fifo: RTL and testbench
======================================

# ether_tx_frame_fifo

Transmit frame buffer between the UDP loopback/sender stage and the Ethernet MAC transmitter. It accepts 32-bit frame words from the upstream stage over the TX_WE/TX_START/TX_END interface and stores them in a 1024-word RAM. A frame becomes visible to the MAC side only once it is complete. Committed frames are replayed as a byte stream with valid/ready handshake, last-byte marker and enforced inter-frame gap.

## Interface
- ADDR_W, 10: RAM address width; depth = 2^ADDR_W words.
- MAX_FRAMES, 8: maximum committed-but-unsent frames.
- IFG_CYCLES, 12: idle cycles forced after each frame's last byte.
- CLK  in  1  clock.
- RST  in  1  reset; one clock, synchronous, active-low.
- TX_WE  in  1  write strobe for TX_DATA.
- TX_START  in  1  with TX_WE: first (header) word of a frame.
- TX_END  in  1  with TX_WE: last word of a frame.
- TX_DATA  in  32  frame word.
  - Header word: [31:16] = frame byte length L (no FCS), [15:0] = 0.
  - Payload words: byte n of the frame is in bits [8*(n%4)+7 : 8*(n%4)].
- TX_READY  out  1  high when committed frame count < MAX_FRAMES.
- TX_FULL  out  1  high when free words = 0.
- TX_SPACE  out  ADDR_W  free words = 2^ADDR_W − 1 − (wr_ptr − rd_ptr) mod 2^ADDR_W.
- MAC_TX_DATA  out  8  frame byte.
- MAC_TX_VALID  out  1  byte valid.
- MAC_TX_LAST  out  1  with VALID: final byte of the frame.
- MAC_TX_READY  in  1  MAC accepts the byte this cycle.

## Operation
- **Pointers.**
  - wr_ptr: speculative write pointer.
  - commit_ptr: end of the last complete frame.
  - rd_ptr: read pointer.
  - frame_cnt: committed frames not yet fully sent.
- **Write (TX_WE=1).**
  - A write with TX_START: wr_ptr ← commit_ptr (discards any open partial frame), the word is written, and ovf is cleared.
  - Any other write stores at wr_ptr and increments wr_ptr, unless TX_FULL. A write while TX_FULL is dropped and sets ovf.
  - A write with TX_END and ovf=0: commit_ptr ← new wr_ptr and frame_cnt increments.
  - A write with TX_END and ovf=1: wr_ptr ← commit_ptr, the frame is discarded, and ovf is cleared.
  - TX_START and TX_END on the same write form a header-only frame. It is committed as normal.
- **Read FSM.** States R_IDLE, R_HDR, R_LOAD, R_DATA, R_GAP.
  - R_IDLE: when frame_cnt > 0, issue RAM read at rd_ptr and go to R_HDR.
  - R_HDR: latch L from RAM output.
    - If L = 0: rd_ptr advances past the header, frame_cnt decrements, go to R_IDLE.
    - Otherwise: issue the read of the first payload word and go to R_LOAD.
  - R_LOAD: load the byte shifter and go to R_DATA.
  - R_DATA: present byte; on VALID&&READY advance.
    - The next word is prefetched so that no VALID bubble occurs while READY stays high.
    - The byte with remaining count = 1 asserts MAC_TX_LAST.
    - On its acceptance:
      - rd_ptr ← header address + 1 + ceil(L/4);
      - frame_cnt decrements;
      - go to R_GAP.
  - R_GAP: count IFG_CYCLES cycles, then go to R_IDLE.
- **Simultaneous commit and send-completion:** frame_cnt is unchanged.
- **Wrap-around:** all pointers are modulo 2^ADDR_W. The full/empty distinction comes from the TX_SPACE formula, which reserves 1 word.
- **Reset.** All pointers, frame_cnt and ovf are 0, and the FSM is in R_IDLE. Outputs:
  - MAC_TX_VALID = 0, MAC_TX_LAST = 0, MAC_TX_DATA = 0;
  - TX_READY = 1, TX_FULL = 0, TX_SPACE = 1023.
- **Reset mid-frame:** both partial writes and in-flight reads are abandoned without output glitches after the reset cycle.

## Timing
- RAM is synchronous: read data appears 1 cycle after the address.
- TX_SPACE, TX_FULL and TX_READY are registered from pointer/count state. They reflect a write in the cycle after it.
- Latency: with TX_END written in cycle E, the reader idle and MAC_TX_READY high:
  - MAC_TX_VALID first asserts in cycle E+4;
  - a frame of L bytes occupies exactly L consecutive VALID cycles.
- MAC_TX_DATA, MAC_TX_VALID and MAC_TX_LAST hold stable while VALID && !READY.
- The next frame's first VALID comes no earlier than IFG_CYCLES+4 cycles after the previous LAST acceptance.

## Test plan
- **Single frame.** Write header 0x003C0000 plus 15 payload words (L=60), READY tied high.
  - 60 consecutive bytes in little-endian word order; LAST on byte 60; first VALID at E+4.
  - TX_SPACE is 1007 after the writes and returns to 1023 after the frame is sent.
- **Odd length.** L=61, 16 payload words.
  - Byte 61 = TX_DATA[7:0] of the last word, with LAST.
  - rd_ptr advances by 17.
- **Backpressure.** Toggle MAC_TX_READY pseudo-randomly on L=64.
  - Byte stream is identical to the unstalled case; outputs are stable during stalls.
- **Overflow.**
  - Fill to TX_FULL, then continue writing the same frame to its TX_END: the frame is discarded, frame_cnt is unchanged, and no MAC output.
  - A following START frame is then sent correctly.
- **Abort and wrap.**
  - TX_START mid-frame: the partial frame is discarded.
  - Stream 40 frames of L=100 through the buffer (pointer wrap): all are delivered intact, with ≥12 idle cycles between frames.
- **Frame limit.** Write 8 frames with READY held low.
  - TX_READY goes to 0.
  - Release READY: TX_READY returns to 1 after the first LAST acceptance, and all 8 frames are delivered.

Source files
------------

// File: rtl/ether_tx_frame_fifo.sv
// Store-and-forward transmit frame buffer between the UDP sender and the MAC.
// Frames are written as 32-bit words and replayed as a byte stream once committed.
module ether_tx_frame_fifo #(
    parameter int ADDR_W     = 10,
    parameter int MAX_FRAMES = 8,
    parameter int IFG_CYCLES = 12
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              TX_WE,
    input  logic              TX_START,
    input  logic              TX_END,
    input  logic [31:0]       TX_DATA,
    output logic              TX_READY,
    output logic              TX_FULL,
    output logic [ADDR_W-1:0] TX_SPACE,
    output logic [7:0]        MAC_TX_DATA,
    output logic              MAC_TX_VALID,
    output logic              MAC_TX_LAST,
    input  logic              MAC_TX_READY
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CW    = $clog2(MAX_FRAMES + 1);
    localparam int GW    = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] A_ONE    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_TWO    = ADDR_W'(2);
    localparam logic [CW-1:0]     MAXF     = CW'(MAX_FRAMES);
    localparam logic [GW-1:0]     GAP_LAST = GW'(IFG_CYCLES - 1);

    typedef enum logic [2:0] {R_IDLE, R_HDR, R_LOAD, R_DATA, R_GAP} rstate_e;

    logic [31:0]       mem_q [0:DEPTH-1];
    logic [31:0]       rdata_q;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d, nxt_q, raddr, wbase;
    logic [ADDR_W-1:0] space_q, space_d, commit_free;
    logic              ovf_q, ovf_d, full_q, ready_q;
    logic              mem_we, wdrop, wovf, commit_evt, ren, rd_done;
    logic [CW-1:0]     cnt_q, cnt_d;
    rstate_e           state_q, state_d;
    logic [15:0]       len_q, rem_q, hdr_len;
    logic [1:0]        bidx_q;
    logic [31:0]       shift_q;
    logic [GW-1:0]     gap_q;

    assign hdr_len     = rdata_q[31:16];
    assign commit_free = ~(commit_ptr_q - rd_ptr_q);
    assign space_d     = ~(wr_ptr_d - rd_ptr_d);
    assign cnt_d       = cnt_q + CW'(commit_evt) - CW'(rd_done);
    assign TX_SPACE    = space_q;
    assign TX_FULL     = full_q;
    assign TX_READY    = ready_q;

    always_ff @(posedge CLK) begin
        if (mem_we) mem_q[wbase] <= TX_DATA;
        if (ren)    rdata_q <= mem_q[raddr];
    end

    // A header restarts at commit_ptr; it is dropped only if even that slot would
    // overwrite unsent data, in which case the whole frame is discarded at TX_END.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        ovf_d        = ovf_q;
        mem_we       = 1'b0;
        commit_evt   = 1'b0;
        wbase        = TX_START ? commit_ptr_q : wr_ptr_q;
        wdrop        = TX_START ? (commit_free == '0) : full_q;
        wovf         = (ovf_q && !TX_START) || wdrop;
        if (TX_WE) begin
            wr_ptr_d = wdrop ? wbase : wbase + A_ONE;
            mem_we   = !wdrop;
            ovf_d    = wovf;
            if (TX_END) begin
                if (wovf) begin
                    wr_ptr_d = commit_ptr_q;
                    ovf_d    = 1'b0;
                end else begin
                    commit_ptr_d = wr_ptr_d;
                    commit_evt   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            ovf_q        <= 1'b0;
            cnt_q        <= '0;
            space_q      <= '1;
            full_q       <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            ovf_q        <= ovf_d;
            cnt_q        <= cnt_d;
            space_q      <= space_d;
            full_q       <= (space_d == '0);
            ready_q      <= (cnt_d < MAXF);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) state_q <= R_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            R_IDLE:  if (cnt_q != '0) state_d = R_HDR;
            R_HDR:   state_d = (hdr_len == '0) ? R_IDLE : R_LOAD;
            R_LOAD:  state_d = R_DATA;
            R_DATA:  if (MAC_TX_READY && rem_q == 16'd1) state_d = R_GAP;
            R_GAP:   if (gap_q == GAP_LAST) state_d = R_IDLE;
            default: state_d = R_IDLE;
        endcase
    end

    // rdata_q always holds the word after the one in the shifter, so the
    // refill on the fourth byte costs no VALID bubble.
    always_comb begin
        ren          = 1'b0;
        raddr        = rd_ptr_q;
        rd_done      = 1'b0;
        rd_ptr_d     = rd_ptr_q;
        MAC_TX_VALID = 1'b0;
        MAC_TX_LAST  = 1'b0;
        MAC_TX_DATA  = '0;
        case (state_q)
            R_IDLE: ren = (cnt_q != '0);
            R_HDR: begin
                if (hdr_len == '0) begin
                    rd_done  = 1'b1;
                    rd_ptr_d = rd_ptr_q + A_ONE;
                end else begin
                    ren   = 1'b1;
                    raddr = rd_ptr_q + A_ONE;
                end
            end
            R_LOAD: begin
                ren   = 1'b1;
                raddr = nxt_q;
            end
            R_DATA: begin
                MAC_TX_VALID = 1'b1;
                MAC_TX_LAST  = (rem_q == 16'd1);
                MAC_TX_DATA  = shift_q[7:0];
                if (MAC_TX_READY) begin
                    if (rem_q == 16'd1) begin
                        rd_done  = 1'b1;
                        rd_ptr_d = rd_ptr_q + A_ONE + ADDR_W'(({1'b0, len_q} + 17'd3) >> 2);
                    end else if (bidx_q == 2'd3) begin
                        ren   = 1'b1;
                        raddr = nxt_q;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            rd_ptr_q <= '0;
            len_q    <= '0;
            rem_q    <= '0;
            bidx_q   <= '0;
            shift_q  <= '0;
            nxt_q    <= '0;
            gap_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            case (state_q)
                R_HDR: begin
                    len_q <= hdr_len;
                    nxt_q <= rd_ptr_q + A_TWO;
                end
                R_LOAD: begin
                    shift_q <= rdata_q;
                    rem_q   <= len_q;
                    bidx_q  <= '0;
                    nxt_q   <= nxt_q + A_ONE;
                end
                R_DATA: begin
                    if (MAC_TX_READY) begin
                        rem_q  <= rem_q - 16'd1;
                        bidx_q <= bidx_q + 2'd1;
                        gap_q  <= '0;
                        if (bidx_q == 2'd3) begin
                            shift_q <= rdata_q;
                            nxt_q   <= nxt_q + A_ONE;
                        end else begin
                            shift_q <= {8'h00, shift_q[31:8]};
                        end
                    end
                end
                R_GAP: gap_q <= gap_q + GW'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ether_tx_frame_fifo.sv
// Scoreboard bench for ether_tx_frame_fifo: writers push expected bytes,
// a negedge monitor pops and compares each accepted MAC byte.
module tb_ether_tx_frame_fifo;
    localparam int IFG = 12;

    logic        clk = 1'b0, rst = 1'b0;
    logic        TX_WE, TX_START, TX_END, MAC_TX_READY;
    logic [31:0] TX_DATA;
    logic        TX_READY, TX_FULL, MAC_TX_VALID, MAC_TX_LAST;
    logic [9:0]  TX_SPACE;
    logic [7:0]  MAC_TX_DATA;

    ether_tx_frame_fifo #(.ADDR_W(10), .MAX_FRAMES(8), .IFG_CYCLES(IFG)) dut (
        .CLK(clk), .RST(rst), .TX_WE(TX_WE), .TX_START(TX_START), .TX_END(TX_END),
        .TX_DATA(TX_DATA), .TX_READY(TX_READY), .TX_FULL(TX_FULL), .TX_SPACE(TX_SPACE),
        .MAC_TX_DATA(MAC_TX_DATA), .MAC_TX_VALID(MAC_TX_VALID), .MAC_TX_LAST(MAC_TX_LAST),
        .MAC_TX_READY(MAC_TX_READY)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_chk = 0, n_pass = 0;
    logic [8:0] exp_q[$];
    logic [8:0] e;
    int         frames_done = 0, frame_first = 0, frame_last = 0, valid_cycles = 0;
    int         last_acc = 0, last_wr_cyc = 0;
    bit         in_frame = 0, have_last = 0, stall = 0;
    logic [7:0] hold_d;
    logic       hold_l;

    task automatic chk(input string nm, input bit ok, input int got, input int exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            in_frame = 0; have_last = 0; stall = 0;
        end else if (MAC_TX_VALID) begin
            valid_cycles++;
            if (!in_frame) begin
                in_frame = 1; frame_first = cyc;
                if (have_last) chk("ifg", cyc - last_acc >= IFG + 4, cyc - last_acc, IFG + 4);
            end
            if (stall) begin
                chk("stall_data", MAC_TX_DATA == hold_d, MAC_TX_DATA, hold_d);
                chk("stall_last", MAC_TX_LAST == hold_l, MAC_TX_LAST, hold_l);
            end
            if (MAC_TX_READY) begin
                stall = 0;
                if (exp_q.size() == 0) chk("unexpected_byte", 0, MAC_TX_DATA, -1);
                else begin
                    e = exp_q.pop_front();
                    chk("byte", MAC_TX_DATA == e[7:0], MAC_TX_DATA, e[7:0]);
                    chk("last", MAC_TX_LAST == e[8], MAC_TX_LAST, e[8]);
                end
                if (MAC_TX_LAST) begin
                    in_frame = 0; have_last = 1; last_acc = cyc; frame_last = cyc; frames_done++;
                end
            end else begin
                stall = 1; hold_d = MAC_TX_DATA; hold_l = MAC_TX_LAST;
            end
        end else if (stall) begin
            chk("valid_held", 0, 0, 1);
            stall = 0;
        end
    end

    function automatic logic [7:0] bval(input int seed, input int n);
        return 8'(seed + 3 * n);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] d, input bit s, input bit en);
        TX_WE = 1; TX_START = s; TX_END = en; TX_DATA = d; last_wr_cyc = cyc;
        @(posedge clk); #1;
        TX_WE = 0; TX_START = 0; TX_END = 0;
    endtask

    task automatic frame(input int len, input int seed, input bit push);
        int nw = (len + 3) / 4;
        logic [31:0] w;
        if (push) for (int n = 0; n < len; n++) exp_q.push_back({n == len - 1, bval(seed, n)});
        wr({len[15:0], 16'h0}, 1, nw == 0);
        for (int i = 0; i < nw; i++) begin
            for (int k = 0; k < 4; k++)
                w[8*k +: 8] = (4 * i + k < len) ? bval(seed, 4 * i + k) : 8'hEE;
            wr(w, 0, i == nw - 1);
        end
    endtask

    task automatic wait_frames(input int n, input int budget, input string nm);
        int t = 0;
        while (frames_done < n && t < budget) begin tick(1); t++; end
        chk(nm, frames_done >= n, frames_done, n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int base, e_cyc, cnt, vc, t;
        TX_WE = 0; TX_START = 0; TX_END = 0; TX_DATA = '0; MAC_TX_READY = 1;
        tick(3);
        rst = 1;
        chk("rst_valid", MAC_TX_VALID == 0, MAC_TX_VALID, 0);
        chk("rst_last", MAC_TX_LAST == 0, MAC_TX_LAST, 0);
        chk("rst_data", MAC_TX_DATA == 0, MAC_TX_DATA, 0);
        chk("rst_ready", TX_READY == 1, TX_READY, 1);
        chk("rst_full", TX_FULL == 0, TX_FULL, 0);
        chk("rst_space", TX_SPACE == 1023, TX_SPACE, 1023);

        base = frames_done;
        frame(60, 1, 1);
        e_cyc = last_wr_cyc;
        chk("t1_space_wr", TX_SPACE == 1007, TX_SPACE, 1007);
        wait_frames(base + 1, 200, "t1_done");
        chk("t1_latency", frame_first == e_cyc + 4, frame_first, e_cyc + 4);
        chk("t1_consec", frame_last - frame_first + 1 == 60, frame_last - frame_first + 1, 60);
        tick(2);
        chk("t1_space_back", TX_SPACE == 1023, TX_SPACE, 1023);

        base = frames_done;
        frame(61, 8'h40, 1);
        chk("t2_space_wr", TX_SPACE == 1006, TX_SPACE, 1006);
        wait_frames(base + 1, 200, "t2_done");
        tick(2);
        chk("t2_space_back", TX_SPACE == 1023, TX_SPACE, 1023);

        base = frames_done;
        frame(64, 8'h80, 1);
        t = 0;
        while (frames_done < base + 1 && t < 2000) begin
            tick(1); MAC_TX_READY = 1'($urandom_range(0, 1)); t++;
        end
        MAC_TX_READY = 1;
        wait_frames(base + 1, 50, "t3_done");

        base = frames_done; vc = valid_cycles;
        wr({16'd4200, 16'h0}, 1, 0);
        cnt = 0;
        while (!TX_FULL && cnt < 1100) begin wr(32'h11223344, 0, 0); cnt++; end
        chk("ovf_fill_words", cnt == 1022, cnt, 1022);
        chk("ovf_full", TX_FULL == 1, TX_FULL, 1);
        repeat (3) wr(32'h00000055, 0, 0);
        wr(32'h00000066, 0, 1);
        tick(30);
        chk("ovf_space", TX_SPACE == 1023, TX_SPACE, 1023);
        chk("ovf_ready", TX_READY == 1, TX_READY, 1);
        chk("ovf_no_out", valid_cycles == vc, valid_cycles, vc);
        chk("ovf_frames", frames_done == base, frames_done, base);
        frame(20, 8'h33, 1);
        wait_frames(base + 1, 200, "ovf_next");

        base = frames_done;
        wr({16'd40, 16'h0}, 1, 0);
        repeat (3) wr(32'hDEADBEEF, 0, 0);
        frame(12, 8'h50, 1);
        wait_frames(base + 1, 200, "abort_done");
        tick(2);
        chk("abort_space", TX_SPACE == 1023, TX_SPACE, 1023);

        base = frames_done;
        for (int f = 0; f < 40; f++) begin
            t = 0;
            while (!(TX_READY && TX_SPACE >= 26) && t < 3000) begin tick(1); t++; end
            frame(100, f * 5, 1);
        end
        wait_frames(base + 40, 8000, "wrap_done");
        chk("wrap_drained", exp_q.size() == 0, exp_q.size(), 0);

        MAC_TX_READY = 0;
        base = frames_done;
        for (int f = 0; f < 8; f++) begin
            frame(8, 8'hA0 + f * 16, 1);
            if (f == 6) chk("lim_ready7", TX_READY == 1, TX_READY, 1);
        end
        chk("lim_ready0", TX_READY == 0, TX_READY, 0);
        tick(5);
        chk("lim_ready_hold", TX_READY == 0, TX_READY, 0);
        chk("lim_stalled_valid", MAC_TX_VALID == 1, MAC_TX_VALID, 1);
        MAC_TX_READY = 1;
        t = 0;
        while (frames_done == base && t < 100) begin tick(1); t++; end
        chk("lim_ready_back", TX_READY == 1, TX_READY, 1);
        wait_frames(base + 8, 2000, "lim_all");

        MAC_TX_READY = 0;
        frame(8, 8'h11, 0);
        t = 0;
        while (!MAC_TX_VALID && t < 50) begin tick(1); t++; end
        chk("rmid_valid_seen", MAC_TX_VALID == 1, MAC_TX_VALID, 1);
        wr({16'd80, 16'h0}, 1, 0);
        wr(32'h01020304, 0, 0);
        rst = 0;
        tick(1);
        rst = 1;
        chk("rmid_valid", MAC_TX_VALID == 0, MAC_TX_VALID, 0);
        chk("rmid_last", MAC_TX_LAST == 0, MAC_TX_LAST, 0);
        chk("rmid_data", MAC_TX_DATA == 0, MAC_TX_DATA, 0);
        chk("rmid_space", TX_SPACE == 1023, TX_SPACE, 1023);
        chk("rmid_ready", TX_READY == 1, TX_READY, 1);
        MAC_TX_READY = 1;
        vc = valid_cycles;
        tick(20);
        chk("rmid_no_out", valid_cycles == vc, valid_cycles, vc);
        base = frames_done;
        frame(8, 8'h22, 1);
        wait_frames(base + 1, 100, "rmid_next");
        chk("final_drained", exp_q.size() == 0, exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
